tdc_interval_counter: RTL and testbench
=======================================

Name: tdc_interval_counter

Overview:
- Coarse TDC front end. Measures the number of clk cycles between a rising edge on start_in and the next rising edge on stop_in.
- Emits one 16-bit interval per measurement with a single-cycle valid_data strobe.
- Sits directly upstream of the 9-sample accumulation stage, which consumes interval/valid_data as input_signal/valid_data.

Parameters:
- WIDTH, 16, bit width of the interval counter and of the interval output.
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on start_in and stop_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic in this single domain.
- rst  input  1  reset; asynchronous, active-high.
- enable  input  1  measurement enable, synchronous; 0 aborts or blocks measurement.
- start_in  input  1  asynchronous start pulse from the detector; rising edge is significant.
- stop_in  input  1  asynchronous stop pulse from the detector; rising edge is significant.
- interval  output  WIDTH  last captured interval in clk cycles; held until the next capture.
- valid_data  output  1  one-cycle strobe; interval is new in this cycle.
- overflow  output  1  qualifies the current interval; 1 = saturated, no stop seen.
- busy  output  1  1 while in the COUNT state.

Behaviour:
Reset:
- rst=1 forces state IDLE, counter=0, interval=0, valid_data=0, overflow=0, busy=0.
- Synchronizer chains and previous-sample registers reset to all 1s. An input already high at reset release therefore yields no edge.
Edge detection:
- Each input passes through SYNC_STAGES flops. A rising edge is flagged when the last stage is 1 and its previous sample is 0.
- Detection latency is SYNC_STAGES+1 cycles, identical for both inputs, so interval is unbiased.
State IDLE:
- On start_edge & enable: counter<=1, go to COUNT.
- stop_edge alone is ignored.
- If start_edge and stop_edge occur in the same cycle, start is taken and stop is ignored.
State COUNT:
- busy=1.
- If enable=0: abort to IDLE. No strobe; interval and overflow are unchanged.
- Else if stop_edge: interval<=counter, overflow<=0, valid_data<=1 in the next cycle, go to IDLE.
- Else if counter == 2^WIDTH-1: interval<=all ones, overflow<=1, valid_data<=1 in the next cycle, go to IDLE.
- Else counter<=counter+1.
- start_edge is ignored in COUNT, including when it coincides with stop_edge.
Interval semantics:
- Start detected in cycle N and stop detected in cycle N+k gives interval=k, for k from 1 to 2^WIDTH-2.
- Saturation reports 2^WIDTH-1 with overflow=1.
Output timing:
- interval, overflow and valid_data are registered. valid_data is high exactly one cycle, with interval and overflow already stable in that cycle.
- A new measurement can start in the IDLE cycle right after the strobe.
Reset mid-operation:
- rst asserted in COUNT takes effect immediately (asynchronous): no strobe, outputs cleared.
Width rules:
- The counter is WIDTH bits unsigned and never wraps. It saturates at the all-ones terminal count.

Decomposition:
- Package tdc_pkg holds:
  - the TDC_WIDTH=16 constant;
  - the state encoding constants ST_IDLE and ST_COUNT;
  - the accumulator sample count constant ACC_SAMPLES=9, shared with the downstream stage.
- One sub-module, tdc_edge_sync: SYNC_STAGES synchronizer plus rising-edge detector with reset-to-1 chain. It is instantiated twice, for start and stop.

Test Plan:
- Basic measurement: reset, enable=1, start pulse, stop pulse 100 clk later -> one valid_data pulse, interval=100, overflow=0, busy high for 100 cycles.
- Orphan and duplicate pulses: stop pulse with no prior start -> no valid_data. Start at t=0, second start at t=20, stop at t=50 -> interval=50.
- Overflow: start only, WIDTH=16 -> after 65535 counts, interval=16'hFFFF, overflow=1, one valid_data pulse, busy falls. A following start/stop with a 7-cycle gap -> interval=7, overflow=0.
- Abort: enable dropped 30 cycles after start -> no valid_data, interval keeps its previous value. A following 12-cycle measurement -> interval=12.
- Reset corner: rst asserted mid-count -> all outputs 0 without waiting for a clock edge. start_in held high across reset release -> no measurement until start_in goes low then high again.
- Back-to-back: nine consecutive measurements of 10..18 cycles -> nine strobes in order with intervals 10..18. The downstream accumulator must produce 126.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants for the coarse TDC front end and its downstream accumulator.
// The FSM state encoding also lives here.
package tdc_pkg;

    localparam int TDC_WIDTH   = 16;
    localparam int ACC_SAMPLES = 9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } tdc_state_e;

endpackage

// File: rtl/tdc_interval_counter_if.sv
// Measurement bus between the detector side and the TDC interval counter.
// The master drives the pulses and the enable; the slave (the TDC) returns the interval.
interface tdc_interval_counter_if
    import tdc_pkg::*;
#(
    parameter int WIDTH = TDC_WIDTH
);
    logic             enable;
    logic             start_in;
    logic             stop_in;
    logic [WIDTH-1:0] interval;
    logic             valid_data;
    logic             overflow;
    logic             busy;

    modport master (
        output enable, start_in, stop_in,
        input  interval, valid_data, overflow, busy
    );

    modport slave (
        input  enable, start_in, stop_in,
        output interval, valid_data, overflow, busy
    );

endinterface

// File: rtl/tdc_edge_sync.sv
// Multi-flop synchronizer with a rising-edge detector on the last stage.
// The chain resets to all ones, so an input that is already high at reset release yields no edge.
module tdc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tdc_interval_counter.sv
// Coarse TDC: counts clk cycles from a start rising edge to the next stop rising edge,
// saturating at the all-ones terminal count and flagging overflow.
module tdc_interval_counter
    import tdc_pkg::*;
#(
    parameter int WIDTH       = TDC_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst,
    tdc_interval_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic start_edge;
    logic stop_edge;

    tdc_state_e       state_q,    state_d;
    logic [WIDTH-1:0] counter_q,  counter_d;
    logic [WIDTH-1:0] interval_q, interval_d;
    logic             overflow_q, overflow_d;
    logic             valid_q,    valid_d;

    // Identical synchronizers keep the start and stop detection latencies equal.
    tdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.start_in),
        .edge_o  (start_edge)
    );

    tdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.stop_in),
        .edge_o  (stop_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            counter_q  <= '0;
            interval_q <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            interval_q <= interval_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    // Stop wins over saturation, so a stop seen at the terminal count still reports normally.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        interval_d = interval_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge && bus.enable) begin
                    counter_d = CNT_ONE;
                    state_d   = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (stop_edge) begin
                    interval_d = counter_q;
                    overflow_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else if (counter_q == CNT_MAX) begin
                    interval_d = CNT_MAX;
                    overflow_d = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.interval   = interval_q;
    assign bus.overflow   = overflow_q;
    assign bus.valid_data = valid_q;
    assign bus.busy       = (state_q == ST_COUNT);

endmodule

// File: tb/tb_tdc_interval_counter.sv
// Scoreboard bench for tdc_interval_counter: scenarios push expected intervals,
// a negedge monitor pops and compares on every valid_data strobe.
module tb_tdc_interval_counter;
    import tdc_pkg::*;

    localparam int WIDTH = TDC_WIDTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tdc_interval_counter_if #(.WIDTH(WIDTH)) bus ();

    tdc_interval_counter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] iv;
        logic             ov;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             cur;
    int               checks = 0;
    int               errors = 0;
    int               busy_run = 0;
    int               last_busy_len = 0;
    bit               prev_valid = 0;
    bit               acc_en = 0;
    int               acc_sum = 0;
    int               acc_cnt = 0;
    int               exp_sum = 0;
    logic [WIDTH-1:0] held_iv = '0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int k, input bit ov);
        exp_t e;
        e.iv = WIDTH'(k);
        e.ov = ov;
        exp_q.push_back(e);
        held_iv = e.iv;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start at cycle 0, stop at cycle k: the reference interval is simply k.
    task automatic meas(input int k, input int ws, input int wst);
        push_exp(k, 1'b0);
        for (int c = 0; c <= k + wst; c++) begin
            bus.start_in = (c < ws);
            bus.stop_in  = (c >= k && c < k + wst);
            @(negedge clk);
        end
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_run   = 0;
            prev_valid = 0;
        end else begin
            if (bus.busy) busy_run++;
            else begin
                if (busy_run != 0) last_busy_len = busy_run;
                busy_run = 0;
            end
            if (bus.valid_data && prev_valid) check("strobe_width", 2, 1);
            if (bus.valid_data) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", bus.interval, -1);
                end else begin
                    cur = exp_q.pop_front();
                    check("interval", bus.interval, cur.iv);
                    check("overflow", bus.overflow, cur.ov);
                    if (acc_en) begin
                        acc_sum += int'(bus.interval);
                        acc_cnt++;
                    end
                end
            end
            prev_valid = bus.valid_data;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        tick(3);
        check("rst_interval", bus.interval, 0);
        check("rst_valid", bus.valid_data, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick(3);
        bus.enable = 1'b1;

        // Basic 100-cycle measurement
        meas(100, 2, 2);
        tick(6);
        check("busy_len", last_busy_len, 100);
        check("busy_after", bus.busy, 0);

        // Orphan stop: no strobe expected
        bus.stop_in = 1'b1;
        tick(2);
        bus.stop_in = 1'b0;
        tick(10);
        check("orphan_busy", bus.busy, 0);

        // Duplicate start at 20, stop at 50 -> 50
        push_exp(50, 1'b0);
        for (int c = 0; c <= 52; c++) begin
            bus.start_in = (c < 2) || (c >= 20 && c < 22);
            bus.stop_in  = (c >= 50 && c < 52);
            @(negedge clk);
        end
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        tick(6);

        // Start and stop together in IDLE: start taken; stop at 25 -> 25
        push_exp(25, 1'b0);
        for (int c = 0; c <= 26; c++) begin
            bus.start_in = (c < 1);
            bus.stop_in  = (c < 1) || (c == 25);
            @(negedge clk);
        end
        bus.stop_in = 1'b0;
        tick(6);

        // Start coinciding with stop in COUNT is ignored: interval 30, no new measurement
        push_exp(30, 1'b0);
        for (int c = 0; c <= 31; c++) begin
            bus.start_in = (c < 1) || (c == 30);
            bus.stop_in  = (c == 30);
            @(negedge clk);
        end
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        tick(8);
        check("coincide_busy", bus.busy, 0);

        // Shortest interval and randomized intervals / pulse widths
        meas(1, 1, 1);
        tick(6);
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(300, 1));
            meas(k, int'($urandom_range(3, 1)), int'($urandom_range(3, 1)));
            tick(int'($urandom_range(12, 6)));
        end

        // Abort: enable dropped 30 cycles after start
        bus.start_in = 1'b1;
        tick(1);
        bus.start_in = 1'b0;
        tick(29);
        check("abort_busy_before", bus.busy, 1);
        bus.enable = 1'b0;
        tick(3);
        check("abort_busy_after", bus.busy, 0);
        check("abort_interval_held", bus.interval, held_iv);
        bus.enable = 1'b1;
        tick(3);
        meas(12, 1, 1);
        tick(6);

        // Saturation: start only
        push_exp((1 << WIDTH) - 1, 1'b1);
        bus.start_in = 1'b1;
        tick(1);
        bus.start_in = 1'b0;
        tick(1000);
        check("sat_busy_mid", bus.busy, 1);
        tick(64550);
        check("sat_busy_after", bus.busy, 0);
        check("sat_drained", exp_q.size(), 0);
        check("sat_busy_len", last_busy_len, (1 << WIDTH) - 1);
        meas(7, 1, 1);
        tick(6);

        // Asynchronous reset mid-count, start held high across release
        bus.start_in = 1'b1;
        tick(1);
        bus.start_in = 1'b0;
        tick(40);
        check("rstmid_busy_before", bus.busy, 1);
        #2;
        rst = 1'b1;
        bus.start_in = 1'b1;
        #1;
        check("rstmid_interval", bus.interval, 0);
        check("rstmid_overflow", bus.overflow, 0);
        check("rstmid_valid", bus.valid_data, 0);
        check("rstmid_busy", bus.busy, 0);
        held_iv = '0;
        tick(2);
        rst = 1'b0;
        tick(20);
        check("held_start_busy", bus.busy, 0);
        bus.start_in = 1'b0;
        tick(4);
        meas(15, 1, 1);
        tick(6);

        // Nine back-to-back measurements feeding the accumulator
        acc_en  = 1'b1;
        exp_sum = 0;
        for (int i = 0; i < ACC_SAMPLES; i++) begin
            meas(10 + i, 1, 1);
            exp_sum += 10 + i;
        end
        tick(8);
        acc_en = 1'b0;
        check("acc_count", acc_cnt, ACC_SAMPLES);
        check("acc_sum", acc_sum, exp_sum);
        check("acc_sum_const", acc_sum, 126);

        tick(10);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
